// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU SDRAM slot timing generator: init FSM states,
// one-hot phase chain reset constants, default line geometry and init timing.
package gpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_PRE   = 3'd1,
        ST_AREF  = 3'd2,
        ST_MRS   = 3'd3,
        ST_ALIGN = 3'd4,
        ST_RUN   = 3'd5
    } init_state_t;

    localparam logic [3:0] CYC_RST = 4'b0001;
    localparam logic [3:0] PH_RST  = 4'b0001;

    localparam int LINE_PHASES_DEF = 288;
    localparam int REF_FIRST_DEF   = 280;
    localparam int INIT_WAIT_DEF   = 7200;
    localparam int INIT_REFS_DEF   = 8;

    // One-hot left rotate used by both cycle and phase rings.
    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/gpu_ramseq_init.sv
// SDRAM power-up init sequencer: 100 us wait, precharge-all, auto-refresh burst,
// mode-register-set, then align to a line start and flag ram_rdy.
module gpu_ramseq_init
    import gpu_pkg::*;
#(
    parameter int INIT_WAIT = INIT_WAIT_DEF,
    parameter int INIT_REFS = INIT_REFS_DEF
) (
    input  logic clk,
    input  logic rst,
    // Strobes describe the phase chain state that becomes visible on the next clk,
    // so the registered command strobes line up with the round start itself.
    input  logic round_start_next,
    input  logic line_start_next,
    output logic ini_pre,
    output logic ini_ref,
    output logic ini_mrs,
    output logic ram_rdy
);

    localparam logic [12:0] WAIT_LAST = 13'(INIT_WAIT - 1);
    localparam logic [3:0]  REFS_LAST = 4'(INIT_REFS - 1);

    init_state_t state_reg, state_next;
    logic [12:0] wait_cnt_reg, wait_cnt_next;
    logic [3:0]  ref_cnt_reg, ref_cnt_next;
    logic        pre_reg, pre_next;
    logic        aref_reg, aref_next;
    logic        mrs_reg, mrs_next;
    logic        rdy_reg, rdy_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_WAIT;
            wait_cnt_reg <= '0;
            ref_cnt_reg  <= '0;
            pre_reg      <= 1'b0;
            aref_reg     <= 1'b0;
            mrs_reg      <= 1'b0;
            rdy_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            ref_cnt_reg  <= ref_cnt_next;
            pre_reg      <= pre_next;
            aref_reg     <= aref_next;
            mrs_reg      <= mrs_next;
            rdy_reg      <= rdy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        ref_cnt_next  = ref_cnt_reg;
        pre_next      = 1'b0;
        aref_next     = 1'b0;
        mrs_next      = 1'b0;
        rdy_next      = rdy_reg;
        case (state_reg)
            ST_WAIT: begin
                // Counter parks at its terminal value once the wait expires.
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_PRE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 13'd1;
                end
            end
            ST_PRE: begin
                if (round_start_next) begin
                    pre_next     = 1'b1;
                    ref_cnt_next = '0;
                    state_next   = ST_AREF;
                end
            end
            ST_AREF: begin
                if (round_start_next) begin
                    aref_next = 1'b1;
                    if (ref_cnt_reg == REFS_LAST) begin
                        state_next = ST_MRS;
                    end else begin
                        ref_cnt_next = ref_cnt_reg + 4'd1;
                    end
                end
            end
            ST_MRS: begin
                if (round_start_next) begin
                    mrs_next   = 1'b1;
                    state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (line_start_next) begin
                    rdy_next   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                rdy_next = 1'b1;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    assign ini_pre = pre_reg;
    assign ini_ref = aref_reg;
    assign ini_mrs = mrs_reg;
    assign ram_rdy = rdy_reg;

endmodule

// File: rtl/gpu_ramseq.sv
// SDRAM slot timing generator: free-running one-hot cycle/phase rings, line phase
// counter, refresh window and init sequencer. Optional hsync lock: GPU_RAMSEQ_SYNC_EN.
module gpu_ramseq
    import gpu_pkg::*;
#(
    parameter int LINE_PHASES = LINE_PHASES_DEF,
    parameter int REF_FIRST   = REF_FIRST_DEF,
    parameter int INIT_WAIT   = INIT_WAIT_DEF,
    parameter int INIT_REFS   = INIT_REFS_DEF
) (
    input  logic       clk,
    input  logic       rst,
`ifdef GPU_RAMSEQ_SYNC_EN
    input  logic       hsync,
`endif
    output logic [3:0] ram_cyc,
    output logic [3:0] ram_ph,
    output logic [8:0] ram_ph_ctr,
    output logic       ram_ref,
    output logic       line_start,
    output logic       ini_pre,
    output logic       ini_ref,
    output logic       ini_mrs,
    output logic       ram_rdy
);

    localparam logic [8:0] PH_LAST   = 9'(LINE_PHASES - 1);
    localparam logic [8:0] REF_START = 9'(REF_FIRST);

    logic [3:0] cyc_reg, cyc_next;
    logic [3:0] ph_reg, ph_next;
    logic [8:0] ctr_reg, ctr_next;
    logic       ref_reg, ref_next;
    logic       line_start_reg, line_start_next;
    logic       round_start_next;
    logic       reload;

`ifdef GPU_RAMSEQ_SYNC_EN
    // Stages 0..1 synchronise hsync, stage 2 holds the previous value for edge detect.
    logic [2:0] hs_pipe_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hs_pipe
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hs_pipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    hs_pipe_reg[gi] <= hsync;
                end else begin
                    hs_pipe_reg[gi] <= hs_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign reload = hs_pipe_reg[1] & ~hs_pipe_reg[2];
`else
    assign reload = 1'b0;
`endif

    always_comb begin
        cyc_next = rotl4(cyc_reg);
        ph_next  = cyc_reg[3] ? rotl4(ph_reg) : ph_reg;
        ctr_next = ctr_reg;
        if (cyc_reg[3] && ph_reg[3]) begin
            ctr_next = (ctr_reg == PH_LAST) ? 9'd0 : ctr_reg + 9'd1;
        end
        if (reload) begin
            cyc_next = CYC_RST;
            ph_next  = PH_RST;
            ctr_next = 9'd0;
        end
        round_start_next = ph_next[0] & cyc_next[0];
        line_start_next  = round_start_next & (ctr_next == 9'd0);
        // ram_rdy is already high by the time the counter first reaches the window.
        ref_next         = ram_rdy & (ctr_next >= REF_START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_reg        <= CYC_RST;
            ph_reg         <= PH_RST;
            ctr_reg        <= '0;
            ref_reg        <= 1'b0;
            line_start_reg <= 1'b0;
        end else begin
            cyc_reg        <= cyc_next;
            ph_reg         <= ph_next;
            ctr_reg        <= ctr_next;
            ref_reg        <= ref_next;
            line_start_reg <= line_start_next;
        end
    end

    gpu_ramseq_init #(
        .INIT_WAIT (INIT_WAIT),
        .INIT_REFS (INIT_REFS)
    ) u_init (
        .clk              (clk),
        .rst              (rst),
        .round_start_next (round_start_next),
        .line_start_next  (line_start_next),
        .ini_pre          (ini_pre),
        .ini_ref          (ini_ref),
        .ini_mrs          (ini_mrs),
        .ram_rdy          (ram_rdy)
    );

    assign ram_cyc    = cyc_reg;
    assign ram_ph     = ph_reg;
    assign ram_ph_ctr = ctr_reg;
    assign ram_ref    = ref_reg;
    assign line_start = line_start_reg;

endmodule

// File: tb/tb_gpu_ramseq.sv
// Scoreboard bench for gpu_ramseq: a timeline model indexed by clocks since reset
// release predicts every output; random reset points exercise restart behaviour.
module tb_gpu_ramseq;

    localparam int LINE_PHASES = 288;
    localparam int REF_FIRST   = 280;
    localparam int INIT_WAIT   = 7200;
    localparam int INIT_REFS   = 8;
    localparam int LINE_CLK    = LINE_PHASES * 16;
    // WAIT occupies the first INIT_WAIT clocks; PRE takes the first round start after that.
    localparam int PRE_T  = (INIT_WAIT / 16 + 1) * 16;
    localparam int REF0_T = PRE_T + 16;
    localparam int MRS_T  = REF0_T + 16 * INIT_REFS;
    localparam int RDY_T  = (MRS_T / LINE_CLK + 1) * LINE_CLK;

    typedef struct packed {
        logic [3:0] cyc;
        logic [3:0] ph;
        logic [8:0] ctr;
        logic       rref;
        logic       ls;
        logic       pre;
        logic       aref;
        logic       mrs;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ram_cyc, ram_ph;
    logic [8:0] ram_ph_ctr;
    logic       ram_ref, line_start, ini_pre, ini_ref, ini_mrs, ram_rdy;
`ifdef GPU_RAMSEQ_SYNC_EN
    logic       hsync = 1'b0;
`endif

    int   t = 0;
    int   errors = 0;
    int   checks = 0;
    int   refs_seen = 0;
    obs_t exp_q[$];

    gpu_ramseq dut (
        .clk        (clk),
        .rst        (rst),
`ifdef GPU_RAMSEQ_SYNC_EN
        .hsync      (hsync),
`endif
        .ram_cyc    (ram_cyc),
        .ram_ph     (ram_ph),
        .ram_ph_ctr (ram_ph_ctr),
        .ram_ref    (ram_ref),
        .line_start (line_start),
        .ini_pre    (ini_pre),
        .ini_ref    (ini_ref),
        .ini_mrs    (ini_mrs),
        .ram_rdy    (ram_rdy)
    );

    always #5 clk = ~clk;

    // Expected outputs n clocks after reset release (n=0 is the reset state).
    function automatic obs_t model(input int n);
        obs_t o;
        int   ph_idx;
        ph_idx = (n / 16) % LINE_PHASES;
        o.cyc  = 4'b0001 << (n % 4);
        o.ph   = 4'b0001 << ((n / 4) % 4);
        o.ctr  = 9'(ph_idx);
        o.ls   = (n > 0) && (n % LINE_CLK == 0);
        o.pre  = (n == PRE_T);
        o.aref = (n >= REF0_T) && (n < REF0_T + 16 * INIT_REFS) && ((n - REF0_T) % 16 == 0);
        o.mrs  = (n == MRS_T);
        o.rdy  = (n >= RDY_T);
        o.rref = o.rdy && (ph_idx >= REF_FIRST);
        return o;
    endfunction

    // One clock of stimulus: advance the timeline, optionally change reset, queue expectation.
    task automatic step(input logic new_rst);
        @(posedge clk);
        if (rst) t++;
        #2;
        rst = new_rst;
        if (!new_rst) t = 0;
        exp_q.push_back(model(t));
    endtask

    task automatic run_to(input int target);
        while (t < target) step(1'b1);
    endtask

    task automatic hold_reset(input int n);
        repeat (n) step(1'b0);
    endtask

    // Monitor: compares every presented output vector against the queued expectation.
    initial begin
        obs_t act, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{ram_cyc, ram_ph, ram_ph_ctr, ram_ref, line_start,
                        ini_pre, ini_ref, ini_mrs, ram_rdy};
                checks++;
                if (!rst) refs_seen = 0;
                else if (ini_ref) refs_seen++;
                if (act !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL outputs t=%0d got cyc=%b ph=%b ctr=%0d ref=%b ls=%b pre=%b aref=%b mrs=%b rdy=%b exp cyc=%b ph=%b ctr=%0d ref=%b ls=%b pre=%b aref=%b mrs=%b rdy=%b",
                                 t, act.cyc, act.ph, act.ctr, act.rref, act.ls, act.pre, act.aref, act.mrs, act.rdy,
                                 e.cyc, e.ph, e.ctr, e.rref, e.ls, e.pre, e.aref, e.mrs, e.rdy);
                end
            end
        end
    end

    initial begin
        int cut;
        // Reset state, then release and a random early restart inside WAIT.
        hold_reset(4);
        cut = $urandom_range(6000, 40);
        run_to(cut);
        $display("txn: reset during WAIT at t=%0d", cut);
        hold_reset(3);

        // Restart mid-AREF after the third ini_ref pulse.
        cut = REF0_T + 32 + $urandom_range(15, 1);
        run_to(cut);
        $display("txn: reset during AREF at t=%0d", cut);
        hold_reset($urandom_range(5, 1));

        // Full init, alignment and one complete refresh window plus a line wrap.
        run_to(RDY_T + LINE_CLK + 64);
        $display("txn: full sequence run to t=%0d", t);

        @(negedge clk);
        #1;
        checks++;
        if (refs_seen != INIT_REFS) begin
            errors++;
            $display("FAIL ref_count got=%0d exp=%0d", refs_seen, INIT_REFS);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
